// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the car game sequencer
package game_pkg;

    // Play state encoding; values are visible on game_ctrl.state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CRASH = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // First obstacle of every game drops from the screen centre
    localparam logic [9:0] FIRST_SPAWN_H = 10'd320;
    // Respawn x is this base plus a 9-bit random offset (64..575)
    localparam logic [9:0] SPAWN_BASE_H  = 10'd64;

    // One step of the right-shifting Galois LFSR
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// rtl/game_lfsr.sv - free-running 16-bit Galois LFSR for obstacle spawn positions
//
// Ports:
//   clk    in   pixel clock
//   rst_n  in   asynchronous active-low reset, loads LFSR_SEED
//   value  out  current LFSR state, advances every cycle
module game_lfsr
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - play state machine, falling obstacle, collision and score
//
// Optional feature: define GAME_CTRL_SPEEDUP_EN to make the obstacle fall
// faster as the score grows (step = OBST_STEP + score/5).
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per frame; all game updates happen here
//   start        in   start/restart request, sampled on frame_tick
//   score_reset  in   clears the score on any cycle
//   car_pos_h    in   car centre x
//   state        out  IDLE/PLAY/CRASH/OVER
//   obst_active  out  obstacle should be drawn
//   obst_pos_h   out  obstacle centre x
//   obst_pos_v   out  obstacle top y
//   score        out  current score, saturates at SCORE_MAX
//   crash        out  high while in CRASH
module game_ctrl
    import game_pkg::*;
#(
    parameter int OBST_STEP    = 4,
    parameter int OBST_SIZE    = 32,
    parameter int CAR_SIZE_H   = 32,
    parameter int CAR_POS_V    = 455,
    parameter int SCORE_MAX    = 19,
    parameter int CRASH_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       score_reset,
    input  logic [9:0] car_pos_h,
    output logic [1:0] state,
    output logic       obst_active,
    output logic [9:0] obst_pos_h,
    output logic [9:0] obst_pos_v,
    output logic [4:0] score,
    output logic       crash
);

    localparam int CNT_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRASH_FRAMES - 1);

    game_state_t      st;
    logic [CNT_W-1:0] crash_cnt;
    logic [15:0]      lfsr;

    game_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr)
    );

    // Per-frame fall distance
    logic [10:0] step;
`ifdef GAME_CTRL_SPEEDUP_EN
    // Taken from the registered score, so a respawn speeds up the next frame
    always_comb begin
        step = 11'(OBST_STEP) + 11'(score / 5'd5);
    end
`else
    assign step = 11'(OBST_STEP);
`endif

    // Collision and wrap arithmetic is done 11 bits wide so sums near the
    // bottom of the screen cannot overflow
    logic [10:0] obst_bottom;
    logic [10:0] next_v;
    logic [10:0] diff_h;
    logic [10:0] abs_h;
    logic        hit_v;
    logic        hit_h;
    logic        wrap;
    logic [9:0]  spawn_h;
    logic [4:0]  score_inc;

    always_comb begin
        obst_bottom = {1'b0, obst_pos_v} + 11'(OBST_SIZE);
        next_v      = {1'b0, obst_pos_v} + step;
        // Two's-complement difference of the centres, then magnitude
        diff_h      = {1'b0, obst_pos_h} - {1'b0, car_pos_h};
        abs_h       = diff_h[10] ? (~diff_h + 11'd1) : diff_h;
        hit_v       = obst_bottom > 11'(CAR_POS_V);
        hit_h       = abs_h < 11'((CAR_SIZE_H + OBST_SIZE) / 2);
        wrap        = next_v >= 11'(V_VISIBLE);
        spawn_h     = SPAWN_BASE_H + {1'b0, lfsr[8:0]};
        score_inc   = (score == 5'(SCORE_MAX)) ? score : score + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            obst_active <= 1'b0;
            obst_pos_h  <= FIRST_SPAWN_H;
            obst_pos_v  <= 10'd0;
            score       <= 5'd0;
            crash       <= 1'b0;
            crash_cnt   <= '0;
        end else begin
            if (frame_tick) begin
                case (st)
                    IDLE, OVER: begin
                        if (start) begin
                            st          <= PLAY;
                            obst_active <= 1'b1;
                            obst_pos_v  <= 10'd0;
                            obst_pos_h  <= FIRST_SPAWN_H;
                            score       <= 5'd0;
                        end
                    end
                    PLAY: begin
                        // Collision is judged on the position already on screen
                        if (hit_v && hit_h) begin
                            st        <= CRASH;
                            crash     <= 1'b1;
                            crash_cnt <= '0;
                        end else if (wrap) begin
                            score      <= score_inc;
                            obst_pos_v <= 10'd0;
                            obst_pos_h <= spawn_h;
                        end else begin
                            obst_pos_v <= next_v[9:0];
                        end
                    end
                    CRASH: begin
                        if (crash_cnt == CNT_LAST) begin
                            st          <= OVER;
                            crash       <= 1'b0;
                            obst_active <= 1'b0;
                        end else begin
                            crash_cnt <= crash_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        st <= IDLE;
                    end
                endcase
            end
            // Overrides any same-cycle increment
            if (score_reset) begin
                score <= 5'd0;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic       score_reset;
    logic [9:0] car_pos_h;
    logic [1:0] state;
    logic       obst_active;
    logic [9:0] obst_pos_h;
    logic [9:0] obst_pos_v;
    logic [4:0] score;
    logic       crash;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start       (start),
        .score_reset (score_reset),
        .car_pos_h   (car_pos_h),
        .state       (state),
        .obst_active (obst_active),
        .obst_pos_h  (obst_pos_h),
        .obst_pos_v  (obst_pos_v),
        .score       (score),
        .crash       (crash)
    );

    // hmode: 0 exact x, 1 x must be a legal respawn (64..575), 2 x not checked
    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       act;
        logic [9:0] v;
        logic [9:0] h;
        int         hmode;
        logic [4:0] sc;
        logic       cr;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    // Reference model of the game, driven by the same stimulus as the DUT
    int exp_st, exp_act, exp_v, exp_h, exp_sc, exp_cr, exp_cnt, exp_hmode;
    bit exp_hknown;
    int respawns;
    string cur_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_step();
`ifdef GAME_CTRL_SPEEDUP_EN
        return 4 + exp_sc / 5;
`else
        return 4;
`endif
    endfunction

    task automatic model_reset();
        exp_st = 0; exp_act = 0; exp_v = 0; exp_h = 320; exp_sc = 0;
        exp_cr = 0; exp_cnt = 0; exp_hknown = 1'b1; exp_hmode = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.tag = cur_tag; e.st = 2'(exp_st); e.act = exp_act[0]; e.v = 10'(exp_v);
        e.h = 10'(exp_h); e.hmode = exp_hmode; e.sc = 5'(exp_sc); e.cr = exp_cr[0];
        sb.push_back(e);
    endtask

    task automatic model_step(input logic s, input logic sr, input logic tk);
        int d;
        int stp;
        exp_hmode = exp_hknown ? 0 : 2;
        if (tk) begin
            case (exp_st)
                0, 3: if (s) begin
                    exp_st = 1; exp_act = 1; exp_v = 0; exp_h = 320;
                    exp_hknown = 1'b1; exp_hmode = 0; exp_sc = 0;
                end
                1: begin
                    stp = cur_step();
                    d = exp_h - int'(car_pos_h);
                    if (d < 0) d = -d;
                    if (exp_hknown && (exp_v + 32 > 455) && (d < 32)) begin
                        exp_st = 2; exp_cr = 1; exp_cnt = 0;
                    end else if (exp_v + stp >= 480) begin
                        exp_sc = (exp_sc < 19) ? exp_sc + 1 : 19;
                        exp_v = 0; exp_hknown = 1'b0; exp_hmode = 1;
                        respawns++;
                    end else begin
                        exp_v = exp_v + stp;
                    end
                end
                2: if (exp_cnt == 119) begin
                    exp_st = 3; exp_act = 0; exp_cr = 0;
                end else begin
                    exp_cnt++;
                end
                default: ;
            endcase
        end
        if (sr) exp_sc = 0;
        push_exp();
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_state"}, 32'(state), 32'(e.st));
        chk({e.tag, "_active"}, 32'(obst_active), 32'(e.act));
        chk({e.tag, "_pos_v"}, 32'(obst_pos_v), 32'(e.v));
        chk({e.tag, "_score"}, 32'(score), 32'(e.sc));
        chk({e.tag, "_crash"}, 32'(crash), 32'(e.cr));
        if (e.hmode == 0) begin
            chk({e.tag, "_pos_h"}, 32'(obst_pos_h), 32'(e.h));
        end else if (e.hmode == 1) begin
            chk({e.tag, "_pos_h_range"},
                32'((obst_pos_h >= 10'd64) && (obst_pos_h <= 10'd575)), 32'd1);
        end
    endtask

    // One clock of stimulus: drive at negedge, model, sample at next negedge
    task automatic cyc(input logic s, input logic sr, input logic tk);
        @(negedge clk);
        start = s; score_reset = sr; frame_tick = tk;
        model_step(s, sr, tk);
        @(negedge clk);
        frame_tick = 1'b0; score_reset = 1'b0;
        check_pop();
    endtask

    task automatic check_reset_values(input string tag);
        cur_tag = tag;
        model_reset();
        push_exp();
        check_pop();
    endtask

    initial begin
        int vb;
        bit done6;
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; score_reset = 1'b0;
        car_pos_h = 10'd600; respawns = 0; done6 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_released");

        cur_tag = "idle_no_start";
        cyc(1'b0, 1'b0, 1'b1);
        cur_tag = "start";
        cyc(1'b1, 1'b0, 1'b1);

        // First fall with start held high: only one transition may happen
        cur_tag = "fall";
        for (int i = 0; i < 119; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("fall_v_after_119", 32'(obst_pos_v), 32'd476);
        cur_tag = "first_respawn";
        cyc(1'b1, 1'b0, 1'b1);
        chk("first_respawn_score", 32'(score), 32'd1);
        chk("first_respawn_v", 32'(obst_pos_v), 32'd0);

        cur_tag = "score_reset_no_tick";
        cyc(1'b0, 1'b1, 1'b0);

        // Far-right car never meets a respawned obstacle (x <= 575)
        car_pos_h = 10'd639;
        cur_tag = "run";
        respawns = 0;
        for (int i = 0; i < 5000 && respawns < 20; i++) begin
`ifdef GAME_CTRL_SPEEDUP_EN
            if (!done6 && exp_sc == 10 && exp_v + 6 < 480) begin
                vb = int'(obst_pos_v);
                cyc(1'b0, 1'b0, 1'b1);
                chk("speedup_step6", 32'(int'(obst_pos_v) - vb), 32'd6);
                done6 = 1'b1;
            end else begin
                cyc(1'b0, 1'b0, 1'b1);
            end
`else
            cyc(1'b0, 1'b0, 1'b1);
`endif
        end
        chk("score_saturated", 32'(score), 32'd19);

        // score_reset on the very tick that would increment
        cur_tag = "run2";
        for (int i = 0; i < 200; i++) begin
            if (exp_v + cur_step() >= 480) begin
                cur_tag = "reset_beats_inc";
                cyc(1'b0, 1'b1, 1'b1);
                chk("reset_beats_inc_score", 32'(score), 32'd0);
                break;
            end
            cyc(1'b0, 1'b0, 1'b1);
        end

        // Reset for one cycle in the middle of play
        cur_tag = "run3";
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("mid_reset_after");

        // Crash sequence with the car under the first spawn
        car_pos_h = 10'd320;
        cur_tag = "crash_start";
        cyc(1'b1, 1'b0, 1'b1);
        cur_tag = "crash_fall";
        for (int i = 0; i < 106; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("crash_fall_v_106", 32'(obst_pos_v), 32'd424);
        cur_tag = "crash_hit";
        cyc(1'b0, 1'b0, 1'b1);
        chk("crash_hit_state", 32'(state), 32'd2);
        chk("crash_hit_v_frozen", 32'(obst_pos_v), 32'd424);
        cur_tag = "crash_hold";
        for (int i = 0; i < 119; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("crash_still_crash", 32'(state), 32'd2);
        cur_tag = "to_over";
        cyc(1'b1, 1'b0, 1'b1);
        chk("over_state", 32'(state), 32'd3);
        chk("over_inactive", 32'(obst_active), 32'd0);
        cur_tag = "over_restart";
        cyc(1'b1, 1'b0, 1'b1);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game sequencer for the VGA car game. Owns the play state machine, a single falling obstacle, collision detection against the player car, and the score register. It advances once per video frame on a frame tick from the timing generator. Its outputs feed the pixel-generation logic and the score-digit renderer; it draws no pixels itself.

## Interface
- `OBST_STEP`, default 4: obstacle vertical pixels per frame.
- `OBST_SIZE`, default 32: obstacle width and height in pixels.
- `CAR_SIZE_H`, default 32: car width in pixels.
- `CAR_POS_V`, default 455: top row of the car.
- `SCORE_MAX`, default 19: score saturation value.
- `CRASH_FRAMES`, default 120: length of the crash display, in frames.
- `clk`  in  1: pixel clock. One clock domain.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `frame_tick`  in  1: one-cycle pulse at the first vertical-blanking line.
- `start`  in  1: clean level, sampled only on `frame_tick` cycles.
- `score_reset`  in  1: synchronous score clear.
- `car_pos_h`  in  10: car centre x, range 0..639.
- `state`  out  2: IDLE=0, PLAY=1, CRASH=2, OVER=3.
- `obst_active`  out  1: obstacle is to be drawn.
- `obst_pos_h`  out  10: obstacle centre x.
- `obst_pos_v`  out  10: obstacle top y.
- `score`  out  5: current score, 0..SCORE_MAX.
- `crash`  out  1: high while `state` is CRASH.

## Operation
- Reset values: `state`=IDLE, `obst_active`=0, `obst_pos_h`=320, `obst_pos_v`=0, `score`=0, `crash`=0, crash counter 0, LFSR=16'hACE1.
- All state and position changes happen only on `frame_tick` cycles.
  - Exception: `score_reset` acts on any cycle.
  - Exception: the LFSR advances every cycle.
- IDLE → PLAY: on `frame_tick` with `start`=1. Sets `obst_active`=1, `obst_pos_v`=0, `obst_pos_h`=320 (fixed first spawn), `score`=0.
- PLAY, on each `frame_tick`, in priority order:
  1. Collision check on the *current* registered values: `obst_pos_v + OBST_SIZE > CAR_POS_V` and `|obst_pos_h − car_pos_h| < (CAR_SIZE_H + OBST_SIZE)/2`. If true: go to CRASH, clear the crash counter, freeze the obstacle, no score change.
  2. Else, if `obst_pos_v + step ≥ 480`: score +1 (saturating at SCORE_MAX), `obst_pos_v`=0, `obst_pos_h` = 64 + `lfsr[8:0]` (range 64..575).
  3. Else: `obst_pos_v` += step.
- CRASH: the counter increments per `frame_tick`. When it reaches CRASH_FRAMES−1 on a tick, go to OVER and set `obst_active`=0.
- OVER → PLAY: on `frame_tick` with `start`=1, using the same initialisation as IDLE → PLAY.
- LFSR: 16-bit Galois, mask 16'hB400, shift right, free-running.
- Arithmetic:
  - Comparisons use 11-bit unsigned sums.
  - The horizontal difference is 11-bit signed, then absolute value.
  - `car_pos_h` is used as-is, with no clamping.
- `score_reset`=1 forces `score`=0 in every state. It wins over a same-cycle increment. It does not change `state`.
- `start` held high across many frames causes only one transition per qualifying tick. A held `start` in OVER restarts immediately on the next tick.

## Timing
- All outputs are registered. Each update is visible the cycle after the `frame_tick` (or `score_reset`) cycle.
- No handshake. `frame_tick` must be a single-cycle pulse; consecutive-cycle ticks are each processed.
- `rst_n` asserted mid-frame clears everything immediately. The first tick after deassertion is evaluated from IDLE.

## Configuration
- `GAME_CTRL_SPEEDUP_EN` defined: step = `OBST_STEP + score/5`, where `score/5` is 0..3, so step ranges 4..7. The step is computed from the registered score.
- `GAME_CTRL_SPEEDUP_EN` undefined: step = `OBST_STEP` constant. No divider logic is present.

## Structure
- `game_pkg` contains:
  - the state enum (IDLE, PLAY, CRASH, OVER);
  - `H_VISIBLE`=640 and `V_VISIBLE`=480;
  - the LFSR seed and mask;
  - the first-spawn x of 320.
- One sub-module, `game_lfsr`: free-running 16-bit LFSR with `clk`, `rst_n` and a 16-bit `value` output.

## Test plan
- Reset then `start`=1 on a tick → `state`=PLAY, `obst_pos_v`=0, `obst_pos_h`=320, `obst_active`=1, `score`=0.
- `car_pos_h`=600, OBST_STEP=4, no speedup → after 119 PLAY ticks `obst_pos_v`=476; on tick 120, `score`=1, `obst_pos_v`=0, `obst_pos_h` within 64..575.
- `car_pos_h`=320 → after tick 106 `obst_pos_v`=424; tick 107 → `state`=CRASH, `crash`=1, `obst_pos_v` stays 424.
- From CRASH, 120 further ticks → `state`=OVER, `obst_active`=0; `start`=1 on the next tick → PLAY with `score`=0.
- Score at 19 with a respawn → stays 19. `score_reset` on the same tick as an increment → `score`=0.
- `rst_n` low for 1 cycle mid-PLAY → all outputs at reset values on the next cycle. With speedup on and `score`=10, step is 6 per tick.
